// File: rtl/clock_pkg.sv
// Shared types and limits for the alarm clock set path.
// Holds the set FSM state encoding and the BCD preload range checks.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_HOUR,
        EDIT_MIN,
        COMMIT
    } state_e;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    function automatic logic hour_ok(
        input logic [1:0] t,
        input logic [3:0] u
    );
        return (u <= 4'd9) && ((t < 2'd2) || ((t == 2'd2) && (u <= 4'd3)));
    endfunction

    function automatic logic min_ok(
        input logic [3:0] t,
        input logic [3:0] u
    );
        return (t <= 4'd5) && (u <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// One BCD field (tens/units pair) stepped up or down by one with wrap at 0..MAX.
// Purely combinational; conflicting or absent strobes pass the value through.
module bcd_field_step #(
    parameter int MAX = 59,
    parameter int TW  = 4
) (
    input  logic [TW-1:0] tens_i,
    input  logic [3:0]    ones_i,
    input  logic          up_i,
    input  logic          dn_i,
    output logic [TW-1:0] tens_o,
    output logic [3:0]    ones_o
);

    localparam logic [TW-1:0] MT = TW'(MAX / 10);
    localparam logic [3:0]    MU = 4'(MAX % 10);

    logic at_max;
    logic at_zero;

    assign at_max  = (tens_i == MT) && (ones_i == MU);
    assign at_zero = (tens_i == '0) && (ones_i == 4'd0);

    always_comb begin
        tens_o = tens_i;
        ones_o = ones_i;
        if (up_i && !dn_i) begin
            if (at_max) begin
                tens_o = '0;
                ones_o = 4'd0;
            end else if (ones_i == 4'd9) begin
                tens_o = tens_i + TW'(1);
                ones_o = 4'd0;
            end else begin
                ones_o = ones_i + 4'd1;
            end
        end else if (dn_i && !up_i) begin
            if (at_zero) begin
                tens_o = MT;
                ones_o = MU;
            end else if (ones_i == 4'd0) begin
                tens_o = tens_i - TW'(1);
                ones_o = 4'd9;
            end else begin
                ones_o = ones_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time/alarm set controller: preload, edit hours then minutes,
// then one registered load pulse toward the time or alarm registers.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S    = 10,
    parameter int REPEAT_DELAY = 2
) (
    input  logic       clk_1s,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       sel_alarm,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       editing,
    output logic       field
);

    localparam logic [7:0]  RD      = 8'(REPEAT_DELAY);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_S - 1);

    state_e      state_q;
    logic        target_q;
    logic [1:0]  h1_q;
    logic [3:0]  h0_q;
    logic [3:0]  m1_q;
    logic [3:0]  m0_q;
    logic        set_q;
    logic        inc_q;
    logic        dec_q;
    logic [7:0]  inc_rep_q;
    logic [7:0]  inc_rep_d;
    logic [7:0]  dec_rep_q;
    logic [7:0]  dec_rep_d;
    logic [15:0] to_q;
    logic        ld_time_q;
    logic        ld_alarm_q;
    logic        editing_q;
    logic        field_q;

    logic       rise_set;
    logic       rise_inc;
    logic       rise_dec;
    logic       both;
    logic       in_edit;
    logic       step_up;
    logic       step_dn;
    logic       any_evt;
    logic [1:0] hs_t;
    logic [3:0] hs_u;
    logic [3:0] ms_t;
    logic [3:0] ms_u;

    assign rise_set = btn_set & ~set_q;
    assign rise_inc = btn_inc & ~inc_q;
    assign rise_dec = btn_dec & ~dec_q;
    assign both     = btn_inc & btn_dec;
    assign in_edit  = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN);

    // Advancing the field wins over any step arriving in the same cycle.
    assign step_up = in_edit & ~both & ~rise_set &
                     (rise_inc | (btn_inc & (inc_rep_q >= RD)));
    assign step_dn = in_edit & ~both & ~rise_set &
                     (rise_dec | (btn_dec & (dec_rep_q >= RD)));
    assign any_evt = rise_set | rise_inc | rise_dec | step_up | step_dn;

    always_comb begin
        inc_rep_d = '0;
        dec_rep_d = '0;
        if (in_edit && !both) begin
            if (btn_inc) begin
                if (rise_inc)        inc_rep_d = 8'd1;
                else if (inc_rep_q < RD) inc_rep_d = inc_rep_q + 8'd1;
                else                 inc_rep_d = inc_rep_q;
            end
            if (btn_dec) begin
                if (rise_dec)        dec_rep_d = 8'd1;
                else if (dec_rep_q < RD) dec_rep_d = dec_rep_q + 8'd1;
                else                 dec_rep_d = dec_rep_q;
            end
        end
    end

    bcd_field_step #(.MAX(HOUR_MAX), .TW(2)) u_hour (
        .tens_i (h1_q),
        .ones_i (h0_q),
        .up_i   (step_up & (state_q == EDIT_HOUR)),
        .dn_i   (step_dn & (state_q == EDIT_HOUR)),
        .tens_o (hs_t),
        .ones_o (hs_u)
    );

    bcd_field_step #(.MAX(MIN_MAX), .TW(4)) u_min (
        .tens_i (m1_q),
        .ones_i (m0_q),
        .up_i   (step_up & (state_q == EDIT_MIN)),
        .dn_i   (step_dn & (state_q == EDIT_MIN)),
        .tens_o (ms_t),
        .ones_o (ms_u)
    );

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            target_q   <= 1'b0;
            h1_q       <= '0;
            h0_q       <= '0;
            m1_q       <= '0;
            m0_q       <= '0;
            set_q      <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            inc_rep_q  <= '0;
            dec_rep_q  <= '0;
            to_q       <= '0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            editing_q  <= 1'b0;
            field_q    <= 1'b0;
        end else begin
            set_q      <= btn_set;
            inc_q      <= btn_inc;
            dec_q      <= btn_dec;
            inc_rep_q  <= inc_rep_d;
            dec_rep_q  <= dec_rep_d;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rise_set) begin
                        if (hour_ok(cur_h1, cur_h0)) begin
                            h1_q <= cur_h1;
                            h0_q <= cur_h0;
                        end else begin
                            h1_q <= '0;
                            h0_q <= '0;
                        end
                        if (min_ok(cur_m1, cur_m0)) begin
                            m1_q <= cur_m1;
                            m0_q <= cur_m0;
                        end else begin
                            m1_q <= '0;
                            m0_q <= '0;
                        end
                        target_q  <= sel_alarm;
                        to_q      <= '0;
                        editing_q <= 1'b1;
                        field_q   <= 1'b0;
                        state_q   <= EDIT_HOUR;
                    end
                end
                EDIT_HOUR, EDIT_MIN: begin
                    h1_q <= hs_t;
                    h0_q <= hs_u;
                    m1_q <= ms_t;
                    m0_q <= ms_u;
                    if (rise_set) begin
                        to_q <= '0;
                        if (state_q == EDIT_HOUR) begin
                            field_q <= 1'b1;
                            state_q <= EDIT_MIN;
                        end else begin
                            editing_q  <= 1'b0;
                            field_q    <= 1'b0;
                            ld_time_q  <= ~target_q;
                            ld_alarm_q <= target_q;
                            state_q    <= COMMIT;
                        end
                    end else if (any_evt) begin
                        to_q <= '0;
                    end else if (to_q >= TO_LAST) begin
                        to_q      <= '0;
                        editing_q <= 1'b0;
                        field_q   <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign H_in1    = h1_q;
    assign H_in0    = h0_q;
    assign M_in1    = m1_q;
    assign M_in0    = m0_q;
    assign LD_time  = ld_time_q;
    assign LD_alarm = ld_alarm_q;
    assign editing  = editing_q;
    assign field    = field_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: vector table plus hand-written
// auto-repeat, async reset and timeout sequences.
module tb_clock_set_ctrl;

    logic       clk_1s = 1'b0;
    logic       reset = 1'b1;
    logic       btn_set = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       sel_alarm = 1'b0;
    logic [1:0] cur_h1 = '0;
    logic [3:0] cur_h0 = '0;
    logic [3:0] cur_m1 = '0;
    logic [3:0] cur_m0 = '0;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       editing;
    logic       field;

    clock_set_ctrl #(.TIMEOUT_S(10), .REPEAT_DELAY(2)) dut (
        .clk_1s    (clk_1s),
        .reset     (reset),
        .btn_set   (btn_set),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .sel_alarm (sel_alarm),
        .cur_h1    (cur_h1),
        .cur_h0    (cur_h0),
        .cur_m1    (cur_m1),
        .cur_m0    (cur_m0),
        .H_in1     (H_in1),
        .H_in0     (H_in0),
        .M_in1     (M_in1),
        .M_in0     (M_in0),
        .LD_time   (LD_time),
        .LD_alarm  (LD_alarm),
        .editing   (editing),
        .field     (field)
    );

    always #5 clk_1s = ~clk_1s;

    typedef struct {
        logic       s, i, d, sel;
        logic [1:0] ch1;
        logic [3:0] ch0, cm1, cm0;
        logic [17:0] exp;
    } vec_t;

    vec_t tv[$];
    int nvec = 0;
    int nmis = 0;

    function automatic logic [17:0] e(
        input int h1, input int h0, input int m1, input int m0,
        input int lt, input int la, input int ed, input int f
    );
        return {2'(h1), 4'(h0), 4'(m1), 4'(m0), 1'(lt), 1'(la), 1'(ed), 1'(f)};
    endfunction

    function automatic logic [17:0] obs();
        return {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, editing, field};
    endfunction

    task automatic add(
        input int s, input int i, input int d, input int sel,
        input int ch1, input int ch0, input int cm1, input int cm0,
        input logic [17:0] ex
    );
        vec_t v;
        v.s = 1'(s); v.i = 1'(i); v.d = 1'(d); v.sel = 1'(sel);
        v.ch1 = 2'(ch1); v.ch0 = 4'(ch0); v.cm1 = 4'(cm1); v.cm0 = 4'(cm0);
        v.exp = ex;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        nvec++;
        if (act !== exv) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exv);
        end
    endtask

    task automatic tick();
        @(posedge clk_1s);
        #1;
    endtask

    task automatic btn(input int s, input int i, input int d);
        btn_set = 1'(s);
        btn_inc = 1'(i);
        btn_dec = 1'(d);
        tick();
    endtask

    initial begin
        int n;
        int ldseen;
        logic dropped;

        // 22:58 time target: hour wraps 23->00, minute wraps 59->00, no carry
        add(1,0,0,0, 2,2,5,8, e(2,2,5,8, 0,0,1,0));
        add(0,0,0,0, 2,2,5,8, e(2,2,5,8, 0,0,1,0));
        add(0,1,0,0, 2,2,5,8, e(2,3,5,8, 0,0,1,0));
        add(0,0,0,0, 2,2,5,8, e(2,3,5,8, 0,0,1,0));
        add(0,1,0,0, 2,2,5,8, e(0,0,5,8, 0,0,1,0));
        add(0,0,0,0, 2,2,5,8, e(0,0,5,8, 0,0,1,0));
        add(1,0,0,0, 2,2,5,8, e(0,0,5,8, 0,0,1,1));
        add(0,0,0,0, 2,2,5,8, e(0,0,5,8, 0,0,1,1));
        add(0,1,0,0, 2,2,5,8, e(0,0,5,9, 0,0,1,1));
        add(0,0,0,0, 2,2,5,8, e(0,0,5,9, 0,0,1,1));
        add(0,1,0,0, 2,2,5,8, e(0,0,0,0, 0,0,1,1));
        add(0,0,0,0, 2,2,5,8, e(0,0,0,0, 0,0,1,1));
        add(1,0,0,0, 2,2,5,8, e(0,0,0,0, 1,0,0,0));
        add(0,0,0,0, 2,2,5,8, e(0,0,0,0, 0,0,0,0));
        add(0,0,0,0, 2,2,5,8, e(0,0,0,0, 0,0,0,0));
        // 00:00 alarm target, sel changed after entry must not matter
        add(1,0,0,1, 0,0,0,0, e(0,0,0,0, 0,0,1,0));
        add(0,0,0,0, 0,0,0,0, e(0,0,0,0, 0,0,1,0));
        add(0,0,1,0, 0,0,0,0, e(2,3,0,0, 0,0,1,0));
        add(0,0,0,0, 0,0,0,0, e(2,3,0,0, 0,0,1,0));
        add(1,0,0,0, 0,0,0,0, e(2,3,0,0, 0,0,1,1));
        add(0,0,0,0, 0,0,0,0, e(2,3,0,0, 0,0,1,1));
        add(0,0,1,0, 0,0,0,0, e(2,3,5,9, 0,0,1,1));
        add(0,0,0,0, 0,0,0,0, e(2,3,5,9, 0,0,1,1));
        add(1,0,0,0, 0,0,0,0, e(2,3,5,9, 0,1,0,0));
        add(0,0,0,0, 0,0,0,0, e(2,3,5,9, 0,0,0,0));
        // 27:63 coerced to 00:00; inc+dec together is ignored
        add(1,0,0,0, 2,7,6,3, e(0,0,0,0, 0,0,1,0));
        add(0,0,0,0, 2,7,6,3, e(0,0,0,0, 0,0,1,0));
        add(0,1,1,0, 2,7,6,3, e(0,0,0,0, 0,0,1,0));
        add(0,0,0,0, 2,7,6,3, e(0,0,0,0, 0,0,1,0));
        add(0,1,0,0, 2,7,6,3, e(0,1,0,0, 0,0,1,0));
        add(0,0,0,0, 2,7,6,3, e(0,1,0,0, 0,0,1,0));
        add(1,0,0,0, 2,7,6,3, e(0,1,0,0, 0,0,1,1));
        add(0,0,0,0, 2,7,6,3, e(0,1,0,0, 0,0,1,1));
        add(0,1,1,0, 2,7,6,3, e(0,1,0,0, 0,0,1,1));
        add(0,0,0,0, 2,7,6,3, e(0,1,0,0, 0,0,1,1));
        add(1,0,0,0, 2,7,6,3, e(0,1,0,0, 1,0,0,0));
        add(0,0,0,0, 2,7,6,3, e(0,1,0,0, 0,0,0,0));
        // hour units 12 is non-BCD -> hour 00; set and inc together commits
        add(1,0,0,0, 1,12,4,5, e(0,0,4,5, 0,0,1,0));
        add(0,0,0,0, 1,12,4,5, e(0,0,4,5, 0,0,1,0));
        add(0,0,1,0, 1,12,4,5, e(2,3,4,5, 0,0,1,0));
        add(0,0,0,0, 1,12,4,5, e(2,3,4,5, 0,0,1,0));
        add(1,0,0,0, 1,12,4,5, e(2,3,4,5, 0,0,1,1));
        add(0,0,0,0, 1,12,4,5, e(2,3,4,5, 0,0,1,1));
        add(1,1,0,0, 1,12,4,5, e(2,3,4,5, 1,0,0,0));
        add(0,0,0,0, 1,12,4,5, e(2,3,4,5, 0,0,0,0));

        #2;
        chk("reset_outputs", 32'(obs()), 32'(e(0,0,0,0, 0,0,0,0)));
        @(posedge clk_1s);
        #2 reset = 1'b0;
        tick();
        chk("after_reset_idle", 32'(obs()), 32'(e(0,0,0,0, 0,0,0,0)));

        foreach (tv[k]) begin
            btn_set = tv[k].s;
            btn_inc = tv[k].i;
            btn_dec = tv[k].d;
            sel_alarm = tv[k].sel;
            cur_h1 = tv[k].ch1;
            cur_h0 = tv[k].ch0;
            cur_m1 = tv[k].cm1;
            cur_m0 = tv[k].cm0;
            tick();
            nvec++;
            if (obs() !== tv[k].exp) begin
                nmis++;
                $display("FAIL vec%0d: got %h expected %h", k, obs(), tv[k].exp);
            end
        end

        // auto-repeat: steps on rise, then cycles 3,4,5 of the hold
        cur_h1 = 2'd1; cur_h0 = 4'd2; cur_m1 = 4'd1; cur_m0 = 4'd0;
        sel_alarm = 1'b0;
        btn(1,0,0); btn(0,0,0); btn(1,0,0); btn(0,0,0);
        chk("rpt_start", 32'(obs()), 32'(e(1,2,1,0, 0,0,1,1)));
        btn(0,1,0); chk("rpt_c1", 32'({M_in1, M_in0}), 32'h11);
        btn(0,1,0); chk("rpt_c2", 32'({M_in1, M_in0}), 32'h11);
        btn(0,1,0); chk("rpt_c3", 32'({M_in1, M_in0}), 32'h12);
        btn(0,1,0); chk("rpt_c4", 32'({M_in1, M_in0}), 32'h13);
        btn(0,1,0); chk("rpt_c5", 32'({M_in1, M_in0}), 32'h14);
        btn(0,0,0);
        chk("rpt_hold", 32'(obs()), 32'(e(1,2,1,4, 0,0,1,1)));

        // async reset while in EDIT_MIN aborts with no later load
        #2 reset = 1'b1;
        #1 chk("mid_reset", 32'(obs()), 32'(e(0,0,0,0, 0,0,0,0)));
        @(posedge clk_1s);
        #2 reset = 1'b0;
        ldseen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (obs() !== e(0,0,0,0, 0,0,0,0)) ldseen++;
        end
        chk("post_reset_quiet", 32'(ldseen), 32'd0);

        // timeout after TIMEOUT_S quiet cycles in edit, no load
        cur_h1 = 2'd0; cur_h0 = 4'd5; cur_m1 = 4'd3; cur_m0 = 4'd0;
        btn(1,0,0);
        chk("to_entry", 32'(obs()), 32'(e(0,5,3,0, 0,0,1,0)));
        n = 0;
        ldseen = 0;
        dropped = 1'b0;
        for (int k = 1; k <= 20 && !dropped; k++) begin
            btn(0,0,0);
            if (LD_time || LD_alarm) ldseen++;
            if (!editing) begin
                dropped = 1'b1;
                n = k;
            end
        end
        chk("to_cycles", 32'(n), 32'd10);
        chk("to_no_ld", 32'(ldseen), 32'd0);
        chk("to_final", 32'(obs()), 32'(e(0,5,3,0, 0,0,0,0)));
        btn(0,0,0);
        chk("to_idle_hold", 32'(obs()), 32'(e(0,5,3,0, 0,0,0,0)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
